pipe_collide_score: RTL and testbench



---
 rtl/flappy_pkg.sv | 20 ++
 rtl/pipe_hit_check.sv | 37 +++
 rtl/pipe_collide_score.sv | 137 +++++++++++++
 tb/tb_pipe_collide_score.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy collision/score path.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam logic [7:0]  KEY_FLAP = 8'h1A;
  localparam int unsigned SCORE_W  = 27;
  localparam logic [9:0]  X_MAX    = 10'd639;
  localparam logic [9:0]  Y_MAX    = 10'd479;

  // Zero-extend a 10-bit screen coordinate into the 12-bit signed compare domain.
  function automatic logic signed [11:0] to_s12(input logic [9:0] v);
    return $signed({2'b00, v});
  endfunction

endpackage

// File: rtl/pipe_hit_check.sv
// Per-pipe combinational pass and collision detection against the bird box.
module pipe_hit_check
  import flappy_pkg::*;
(
  input  logic [9:0] BirdX,
  input  logic [9:0] BirdY,
  input  logic [9:0] BirdS,
  input  logic [9:0] PipeX,
  input  logic [9:0] PipeY,
  input  logic [9:0] prev_x,
  input  logic [9:0] pipe_half_w,
  input  logic [9:0] gap_half,
  output logic       passed,
  output logic       collide
);

  logic signed [11:0] bx, by, bs, px, py, pv, hw, gh;
  logic signed [11:0] dx, adx;

  assign bx = to_s12(BirdX);
  assign by = to_s12(BirdY);
  assign bs = to_s12(BirdS);
  assign px = to_s12(PipeX);
  assign py = to_s12(PipeY);
  assign pv = to_s12(prev_x);
  assign hw = to_s12(pipe_half_w);
  assign gh = to_s12(gap_half);

  assign dx  = px - bx;
  assign adx = dx[11] ? -dx : dx;

  // Only a right-to-left crossing of BirdX counts; the wrap reload moves the other way.
  assign passed  = (pv >= bx) && (px < bx);
  assign collide = (adx <= (hw + bs)) &&
                   (((by - bs) < (py - gh)) || ((by + bs) > (py + gh)));

endmodule

// File: rtl/pipe_collide_score.sv
// Game-state FSM and saturating score counter, one step per frame_clk.
// Optional FLAPPY_HISCORE_EN adds a hi_score output kept across games.
module pipe_collide_score
  import flappy_pkg::*;
#(
  parameter int unsigned         NUM_PIPES   = 3,
  parameter logic [9:0]          PIPE_HALF_W = 10'd26,
  parameter logic [9:0]          GAP_HALF    = 10'd60,
  parameter logic [9:0]          GROUND_Y    = Y_MAX,
  parameter logic [7:0]          DEAD_HOLD   = 8'd120,
  parameter logic [SCORE_W-1:0]  SCORE_MAX   = 27'd99_999_999
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic [7:0]             keycode,
  input  logic [9:0]             BirdX,
  input  logic [9:0]             BirdY,
  input  logic [9:0]             BirdS,
  input  logic [NUM_PIPES*10-1:0] PipeX,
  input  logic [NUM_PIPES*10-1:0] PipeY,
  output logic [SCORE_W-1:0]     score,
  output logic [1:0]             game_state,
  output logic                   pass_pulse,
`ifdef FLAPPY_HISCORE_EN
  output logic [SCORE_W-1:0]     hi_score,
`endif
  output logic                   hit
);

  localparam int unsigned CNT_W = $clog2(NUM_PIPES + 1);

  game_state_t            state, state_n;
  logic [SCORE_W-1:0]     score_n;
  logic [7:0]             hold_cnt, hold_n;
  logic [NUM_PIPES*10-1:0] prev_x;
  logic                   pass_n, hit_n;
  logic [NUM_PIPES-1:0]   passed, collide;
  logic [CNT_W-1:0]       pass_cnt;
  logic [SCORE_W:0]       score_sum;
  logic                   ground, any_col;
`ifdef FLAPPY_HISCORE_EN
  logic [SCORE_W-1:0]     hi_n;
`endif

  for (genvar i = 0; i < int'(NUM_PIPES); i++) begin : g_chk
    pipe_hit_check u_chk (
      .BirdX       (BirdX),
      .BirdY       (BirdY),
      .BirdS       (BirdS),
      .PipeX       (PipeX[10*i +: 10]),
      .PipeY       (PipeY[10*i +: 10]),
      .prev_x      (prev_x[10*i +: 10]),
      .pipe_half_w (PIPE_HALF_W),
      .gap_half    (GAP_HALF),
      .passed      (passed[i]),
      .collide     (collide[i])
    );
  end

  // Number of pipes crossed this frame.
  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < int'(NUM_PIPES); i++) begin
      pass_cnt = pass_cnt + CNT_W'(passed[i]);
    end
  end

  assign ground    = ({2'b00, BirdY} + {2'b00, BirdS}) >= {2'b00, GROUND_Y};
  assign any_col   = ground || (|collide);
  assign score_sum = {1'b0, score} + (SCORE_W + 1)'(pass_cnt);

  // Next-state, score and pulse decode; collision takes priority over scoring.
  always_comb begin
    state_n = state;
    score_n = score;
    hold_n  = hold_cnt;
    pass_n  = 1'b0;
    hit_n   = 1'b0;
`ifdef FLAPPY_HISCORE_EN
    hi_n    = hi_score;
`endif
    case (state)
      IDLE: begin
        if (keycode == KEY_FLAP) begin
          state_n = PLAY;
          score_n = '0;
        end
      end
      PLAY: begin
        if (any_col) begin
          state_n = DEAD;
          hit_n   = 1'b1;
          hold_n  = DEAD_HOLD;
`ifdef FLAPPY_HISCORE_EN
          hi_n    = (score > hi_score) ? score : hi_score;
`endif
        end else if (pass_cnt != '0) begin
          pass_n  = 1'b1;
          score_n = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
        end
      end
      DEAD: begin
        if (hold_cnt == 8'd0) state_n = IDLE;
        else                  hold_n  = hold_cnt - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // All frame state; pipe history is refreshed every frame regardless of state.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      score      <= '0;
      hold_cnt   <= 8'd0;
      prev_x     <= '0;
      pass_pulse <= 1'b0;
      hit        <= 1'b0;
`ifdef FLAPPY_HISCORE_EN
      hi_score   <= '0;
`endif
    end else begin
      state      <= state_n;
      score      <= score_n;
      hold_cnt   <= hold_n;
      prev_x     <= PipeX;
      pass_pulse <= pass_n;
      hit        <= hit_n;
`ifdef FLAPPY_HISCORE_EN
      hi_score   <= hi_n;
`endif
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_pipe_collide_score.sv
// Directed plus random frames against a frame-level reference model of the game rules.
module tb_pipe_collide_score;
  import flappy_pkg::*;

  localparam int NP   = 3;
  localparam int SMAX = 20;

  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic [7:0]  keycode;
  logic [9:0]  BirdX, BirdY, BirdS;
  logic [NP*10-1:0] PipeX, PipeY;
  logic [26:0] score;
  logic [1:0]  game_state;
  logic        pass_pulse, hit;
`ifdef FLAPPY_HISCORE_EN
  logic [26:0] hi_score;
`endif

  always #5 frame_clk = ~frame_clk;

  pipe_collide_score #(.SCORE_MAX(27'(SMAX))) dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .keycode    (keycode),
    .BirdX      (BirdX),
    .BirdY      (BirdY),
    .BirdS      (BirdS),
    .PipeX      (PipeX),
    .PipeY      (PipeY),
    .score      (score),
    .game_state (game_state),
    .pass_pulse (pass_pulse),
`ifdef FLAPPY_HISCORE_EN
    .hi_score   (hi_score),
`endif
    .hit        (hit)
  );

  int vectors = 0, miscompares = 0;

  // Stimulus as plain integers.
  int bx, by, bs, key;
  int px[NP], py[NP];

  // Reference model state.
  int m_state, m_score, m_hold, m_hi;
  int m_prev[NP];
  int m_pulse, m_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    keycode = 8'(key);
    BirdX = 10'(bx);
    BirdY = 10'(by);
    BirdS = 10'(bs);
    for (int i = 0; i < NP; i++) begin
      PipeX[10*i +: 10] = 10'(px[i]);
      PipeY[10*i +: 10] = 10'(py[i]);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_hold = 0; m_hi = 0; m_pulse = 0; m_hit = 0;
    for (int i = 0; i < NP; i++) m_prev[i] = 0;
  endtask

  // One frame of game rules: start key, pass/collision scoring, dead hold.
  task automatic model_step();
    int np, d;
    bit col;
    np = 0; col = 0;
    m_pulse = 0; m_hit = 0;
    case (m_state)
      0: if (key == 8'h1A) begin m_state = 1; m_score = 0; end
      1: begin
        if (by + bs >= 479) col = 1;
        for (int i = 0; i < NP; i++) begin
          d = px[i] - bx;
          if (d < 0) d = -d;
          if (d <= 26 + bs && ((by - bs) < (py[i] - 60) || (by + bs) > (py[i] + 60))) col = 1;
          if (m_prev[i] >= bx && px[i] < bx) np++;
        end
        if (col) begin
          m_state = 2; m_hit = 1; m_hold = 120;
          if (m_score > m_hi) m_hi = m_score;
        end else if (np > 0) begin
          m_pulse = 1;
          m_score = (m_score + np > SMAX) ? SMAX : m_score + np;
        end
      end
      default: begin
        if (m_hold == 0) m_state = 0;
        else m_hold--;
      end
    endcase
    for (int i = 0; i < NP; i++) m_prev[i] = px[i];
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_state"}, 32'(game_state), 32'(m_state));
    check({tag, "_score"}, 32'(score), 32'(m_score));
    check({tag, "_pulse"}, 32'(pass_pulse), 32'(m_pulse));
    check({tag, "_hit"}, 32'(hit), 32'(m_hit));
`ifdef FLAPPY_HISCORE_EN
    check({tag, "_hi"}, 32'(hi_score), 32'(m_hi));
`endif
  endtask

  task automatic frame(input string tag);
    drive();
    model_step();
    @(posedge frame_clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    Reset_n = 1'b0;
    bx = 100; by = 240; bs = 4; key = 0;
    px[0] = 400; px[1] = 500; px[2] = 600;
    for (int i = 0; i < NP; i++) py[i] = 240;
    drive();
    model_reset();
    #12;
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_pulse", 32'(pass_pulse), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    Reset_n = 1'b1;

    // Start
    frame("idle");
    key = 8'h1A; frame("start"); key = 0;
    check("start_play", 32'(game_state), 32'd1);

    // Single pass, then pulse must drop
    px[0] = 101; frame("pre");
    px[0] = 99;  frame("pass");
    check("pass_score", 32'(score), 32'd1);
    check("pass_pulse_hi", 32'(pass_pulse), 32'd1);
    px[0] = 97;  frame("post");
    check("pulse_once", 32'(pass_pulse), 32'd0);

    // Wrap reload never counts
    px[0] = 0;   frame("wrap0");
    px[0] = 639; frame("wrap");
    check("wrap_score", 32'(score), 32'd1);
    check("wrap_pulse", 32'(pass_pulse), 32'd0);

    // Collision above the gap
    px[0] = 110; by = 180; frame("col");
    check("col_hit", 32'(hit), 32'd1);
    check("col_dead", 32'(game_state), 32'd2);
    by = 240;
    key = 8'h1A;
    for (int k = 0; k < 120; k++) frame("dead");
    check("dead_hold", 32'(game_state), 32'd2);
    key = 0;
    frame("to_idle");
    check("idle_back", 32'(game_state), 32'd0);
    check("idle_score_kept", 32'(score), 32'd1);

    // Pass and collision in the same frame
    key = 8'h1A; frame("restart"); key = 0;
    check("restart_score", 32'(score), 32'd0);
    px[0] = 101; frame("prio_pre");
    px[0] = 99; by = 180; frame("prio");
    check("prio_dead", 32'(game_state), 32'd2);
    check("prio_score", 32'(score), 32'd0);
    by = 240;

    // Async reset in DEAD with 50 frames of hold left
    for (int k = 0; k < 70; k++) frame("hold");
    #2;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_state", 32'(game_state), 32'd0);
    check("arst_score", 32'(score), 32'd0);
    check("arst_hit", 32'(hit), 32'd0);
    #2;
    Reset_n = 1'b1;

    // Ground at the exact boundary
    px[0] = 400; px[1] = 500; px[2] = 600;
    key = 8'h1A; frame("g_start"); key = 0;
    by = 474; frame("g_safe");
    check("ground_safe", 32'(game_state), 32'd1);
    by = 475; frame("ground");
    check("ground_dead", 32'(game_state), 32'd2);
    by = 240;
    for (int k = 0; k < 200 && m_state != 0; k++) frame("g_wait");

    // Saturation with triple passes
    key = 8'h1A; frame("s_start"); key = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NP; i++) px[i] = 101;
      frame("s_pre");
      for (int i = 0; i < NP; i++) px[i] = 99;
      frame("s_pass");
    end
    check("sat_score", 32'(score), 32'(SMAX));
    check("sat_pulse", 32'(pass_pulse), 32'd1);

    // Random play
    px[0] = 300; px[1] = 513; px[2] = 639;
    for (int k = 0; k < 2500; k++) begin
      key = ($urandom_range(0, 9) == 0) ? 8'h1A : 8'($urandom_range(0, 255) & 8'h0F);
      if ($urandom_range(0, 99) == 0) bx = $urandom_range(80, 120);
      if ($urandom_range(0, 49) == 0) bs = $urandom_range(3, 8);
      by = ($urandom_range(0, 49) == 0) ? $urandom_range(400, 478) : 220 + $urandom_range(0, 40);
      for (int i = 0; i < NP; i++) begin
        px[i] = px[i] - $urandom_range(1, 3);
        if (px[i] < 0) begin
          px[i] = 639;
          py[i] = $urandom_range(180, 300);
        end
      end
      frame("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
